ps2_rx_fifo: RTL and testbench

- Parametrised PS/2 keyboard receiver. Successor to the current single-byte keyboard port.
- Adds an input synchroniser and deglitch filter, a frame timeout, frame-error reporting, and a first-word-fall-through scan-code FIFO of configurable depth with occupancy count.
- Sits between the board PS2 pins and the CPU keyboard MMIO read port.

---
 rtl/ps2_rx_fifo.sv | 174 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with deglitch, frame timeout and FWFT scan-code FIFO
// Optional: define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_fifo #(
  parameter int DEPTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       rd,
  output logic [7:0]                 data,
  output logic                       ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_filt;
  logic                   r_filt_prev;
  logic [FW-1:0]          r_filt_cnt;

  state_t                 r_state;
  logic [2:0]             r_bitcnt;
  logic [7:0]             r_shift;
  logic [TW-1:0]          r_timer;
  logic                   r_push_req;
  logic [7:0]             r_push_data;
  logic                   r_frame_err;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic                   r_par;
`endif

  logic [7:0]             r_mem [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic                   r_ovf;

  logic w_clk_s;
  logic w_bit_in;
  logic w_edge;
  logic w_frame_ok;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_bit_in = r_dat_sync[SYNC_STAGES-1];
  assign w_edge   = r_filt_prev & ~r_filt;

`ifdef PS2_RX_PARITY_CHECK_EN
  assign w_frame_ok = w_bit_in & (^{r_shift, r_par});
`else
  assign w_frame_ok = w_bit_in;
`endif

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_dat_sync  <= '1;
      r_filt      <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_filt_prev <= r_filt;
      if (w_clk_s == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_push_req  <= 1'b0;
    r_frame_err <= 1'b0;
    if (rst) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_timer     <= '0;
      r_push_data <= '0;
`ifdef PS2_RX_PARITY_CHECK_EN
      r_par       <= 1'b0;
`endif
    end else if (r_state == S_IDLE) begin
      r_timer <= '0;
      if (w_edge && !w_bit_in) begin
        r_state  <= S_DATA;
        r_bitcnt <= '0;
      end
    end else if (w_edge) begin
      r_timer <= '0;
      case (r_state)
        S_DATA: begin
          r_shift <= {w_bit_in, r_shift[7:1]};
          if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          else                  r_bitcnt <= r_bitcnt + 1'b1;
        end
        S_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
          r_par   <= w_bit_in;
`endif
          r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_frame_ok) begin
            r_push_req  <= 1'b1;
            r_push_data <= r_shift;
          end else begin
            r_frame_err <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
      r_state     <= S_IDLE;
      r_frame_err <= 1'b1;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_pop  = rd & (r_count != '0);
  assign w_push = r_push_req & ((r_count != CW'(DEPTH)) | w_pop);
  assign w_drop = r_push_req & ~w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop)     r_ovf <= 1'b1;
      else if (w_pop) r_ovf <= 1'b0;
    end
  end

  assign data      = r_mem[r_rptr];
  assign ready     = (r_count != '0);
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int FL    = 4;
  localparam int H     = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd;
  logic [7:0] data;
  logic       ready;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  int         n_total = 0;
  int         n_bad   = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(FL), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd),
    .data(data), .ready(ready), .count(count), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(FL - 1);
      ps2_clk = 1'b1;
      wait_cyc(H - 5 - (FL - 1));
    end else begin
      wait_cyc(H);
    end
    ps2_clk = 1'b0;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0);
  endtask

  // mode 0: plain, 1: check push latency, 2: pop during the push cycle
  task automatic send_frame(input logic [7:0] d, input logic par_bad, input int mode, input int glitch_bit);
    logic valid;
    logic [7:0] hd;
`ifdef PS2_RX_PARITY_CHECK_EN
    valid = !par_bad;
`else
    valid = 1'b1;
`endif
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch_bit == i);
    ps2_bit((~^d) ^ par_bad, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(H);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      wait_cyc(7);
      check("lat_ready_early", ready, 0);
      wait_cyc(1);
      check("lat_ready", ready, 1);
      check("lat_count", count, 1);
      check("lat_data", data, d);
      wait_cyc(H - 8);
    end else if (mode == 2) begin
      wait_cyc(7);
      if (exp_q.size() > 0) begin
        hd = exp_q.pop_front();
        check("push_pop_head", data, hd);
      end
      rd = 1'b1;
      wait_cyc(1);
      rd = 1'b0;
      exp_ovf = 1'b0;
      wait_cyc(H - 8);
    end else begin
      wait_cyc(H);
    end
    ps2_clk = 1'b1;
    wait_cyc(H);
    if (valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic pop_one();
    logic [7:0] hd;
    check("pop_ready", ready, 1);
    if (exp_q.size() > 0) begin
      hd = exp_q.pop_front();
      check("pop_data", data, hd);
    end
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
    exp_ovf = 1'b0;
    check("pop_count", count, exp_q.size());
    check("pop_ovf", overflow, exp_ovf);
  endtask

  initial begin
    int e0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
    wait_cyc(3);
    check("rst_data", data, 0);
    check("rst_ready", ready, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    wait_cyc(5);

    send_frame(8'h1C, 1'b0, 1, -1);
    pop_one();
    check("empty_ready", ready, 0);

    for (int i = 1; i <= 8; i++) send_frame(i[7:0], 1'b0, 0, -1);
    check("full_count", count, 8);
    check("full_ovf", overflow, 0);
    send_frame(8'h09, 1'b0, 0, -1);
    check("ovf_set", overflow, exp_ovf);
    check("ovf_count", count, 8);
    check("ovf_head", data, 8'h01);
    for (int i = 0; i < 8; i++) pop_one();
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
    check("rd_empty_count", count, 0);

    for (int i = 1; i <= 8; i++) send_frame(i[7:0], 1'b0, 0, -1);
    send_frame(8'h09, 1'b0, 2, -1);
    check("pp_count", count, 8);
    check("pp_ovf", overflow, 0);
    while (exp_q.size() > 0) pop_one();

    e0 = err_cnt;
    send_frame(8'hF0, 1'b1, 0, -1);
`ifdef PS2_RX_PARITY_CHECK_EN
    check("par_err", err_cnt - e0, 1);
    check("par_count", count, 0);
`else
    check("par_noerr", err_cnt - e0, 0);
    check("par_data", data, 8'hF0);
    pop_one();
`endif

    e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 0, 3);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_count", count, 1);
    pop_one();

    e0 = err_cnt;
    send_partial(8'h29, 4);
    wait_cyc(4000);
    check("to_early", err_cnt - e0, 0);
    wait_cyc(200);
    check("to_err", err_cnt - e0, 1);
    check("to_count", count, 0);
    send_frame(8'h29, 1'b0, 0, -1);
    check("to_next_count", count, 1);
    pop_one();

    send_frame(8'h33, 1'b0, 0, -1);
    check("pre_rst_count", count, 1);
    send_partial(8'hA5, 5);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    check("mrst_data", data, 0);
    check("mrst_ready", ready, 0);
    check("mrst_count", count, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_ferr", frame_err, 0);
    wait_cyc(5);
    e0 = err_cnt;
    send_frame(8'h77, 1'b0, 0, -1);
    check("post_rst_err", err_cnt - e0, 0);
    pop_one();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
